idma_init_write_pipe: RTL and testbench

//  Registered, flow-controlled INIT write terminator of the iDMA transport layer: pops write-aligned bytes

---
 rtl/idma_init_write_pipe.sv | 130 +++++++++++++
 tb/tb_idma_init_write_pipe.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_init_write_pipe.sv
// idma_init_write_pipe: registered INIT write terminator popping aligned bytes from the dataflow buffer
// Ports:
//   clk_i, rst_i                                  clock, synchronous active-high reset
//   w_dp_offset_i/tailer_i, w_dp_valid_i/ready_o  beat geometry and request handshake
//   dp_poison_i                                   zero the strobe of the current beat
//   w_dp_valid_o/ready_i/err_o                    response returned to the datapath
//   meta_cfg_i/id_i, meta_valid_i/ready_o         write meta handshake
//   init_req_valid_o/ready_i, init_cfg_o/id_o,
//   init_term_o/strb_o                            registered INIT write beat
//   init_rsp_valid_i/ready_o/err_i                INIT response handshake
//   buffer_out_i/valid_i/ready_o                  per-byte buffer interface
//   outstanding_o, idle_o                         in-flight beat count, idle flag
module idma_init_write_pipe #(
    parameter int unsigned StrbWidth       = 16,
    parameter int unsigned OffsetWidth     = $clog2(StrbWidth),
    parameter int unsigned IdWidth         = 4,
    parameter int unsigned CfgWidth        = 32,
    parameter int unsigned MaxOutstanding  = 4,
    parameter bit          MaskInvalidData = 1'b1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [OffsetWidth-1:0]             w_dp_offset_i,
    input  logic [OffsetWidth-1:0]             w_dp_tailer_i,
    input  logic                               w_dp_valid_i,
    output logic                               w_dp_ready_o,
    input  logic                               dp_poison_i,
    output logic                               w_dp_err_o,
    output logic                               w_dp_valid_o,
    input  logic                               w_dp_ready_i,
    input  logic [CfgWidth-1:0]                meta_cfg_i,
    input  logic [IdWidth-1:0]                 meta_id_i,
    input  logic                               meta_valid_i,
    output logic                               meta_ready_o,
    output logic                               init_req_valid_o,
    input  logic                               init_req_ready_i,
    output logic [CfgWidth-1:0]                init_cfg_o,
    output logic [IdWidth-1:0]                 init_id_o,
    output logic [8*StrbWidth-1:0]             init_term_o,
    output logic [StrbWidth-1:0]               init_strb_o,
    input  logic                               init_rsp_valid_i,
    output logic                               init_rsp_ready_o,
    input  logic                               init_rsp_err_i,
    input  logic [8*StrbWidth-1:0]             buffer_out_i,
    input  logic [StrbWidth-1:0]               buffer_out_valid_i,
    output logic [StrbWidth-1:0]               buffer_out_ready_o,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                               idle_o
);
    localparam int unsigned DataWidth = 8*StrbWidth;
    localparam int unsigned OutWidth  = $clog2(MaxOutstanding+1);

    logic [StrbWidth-1:0]   mask, lo_mask, hi_mask;
    logic [OffsetWidth:0]   hi_shift;
    logic [DataWidth-1:0]   term;
    logic                   ready_to_write, load, rsp_hs, rsp_dec;
    logic                   valid_q, valid_d;
    logic [CfgWidth-1:0]    cfg_q, cfg_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic [StrbWidth-1:0]   strb_q, strb_d;
    logic [DataWidth-1:0]   term_q, term_d;
    logic [OutWidth-1:0]    out_q, out_d;

    always_comb begin
        lo_mask  = {StrbWidth{1'b1}} << w_dp_offset_i;
        hi_shift = (OffsetWidth+1)'(StrbWidth) - {1'b0, w_dp_tailer_i};
        hi_mask  = (w_dp_tailer_i != '0) ? {StrbWidth{1'b1}} >> hi_shift : {StrbWidth{1'b1}};
        mask     = lo_mask & hi_mask;
    end

    always_comb begin
        term = buffer_out_i;
        for (int b = 0; b < StrbWidth; b++)
            term[8*b +: 8] = (MaskInvalidData && !mask[b]) ? 8'h00 : buffer_out_i[8*b +: 8];
    end

    // Every masked byte must be present; an empty buffer never feeds a beat, even for an empty mask.
    assign ready_to_write = w_dp_valid_i & meta_valid_i & ((buffer_out_valid_i & mask) == mask)
                          & (buffer_out_valid_i != '0);
    // Credit check uses the registered count, so a response in the same cycle cannot free a slot.
    assign load = ready_to_write & !rst_i & (!valid_q | init_req_ready_i)
                & (out_q < OutWidth'(MaxOutstanding));
    assign rsp_hs  = init_rsp_valid_i & w_dp_ready_i;
    assign rsp_dec = rsp_hs & (out_q != '0);

    assign buffer_out_ready_o = load ? mask : '0;
    assign w_dp_ready_o       = load;
    assign meta_ready_o       = load;
    assign w_dp_valid_o       = init_rsp_valid_i;
    assign init_rsp_ready_o   = w_dp_ready_i;
    assign w_dp_err_o         = init_rsp_err_i;
    assign init_req_valid_o   = valid_q;
    assign init_cfg_o         = cfg_q;
    assign init_id_o          = id_q;
    assign init_strb_o        = strb_q;
    assign init_term_o        = term_q;
    assign outstanding_o      = out_q;
    assign idle_o             = !valid_q & (out_q == '0);

    always_comb begin
        valid_d = load | (valid_q & !init_req_ready_i);
        cfg_d   = load ? meta_cfg_i : cfg_q;
        id_d    = load ? meta_id_i : id_q;
        strb_d  = load ? (dp_poison_i ? '0 : mask) : strb_q;
        term_d  = load ? term : term_q;
        out_d   = (load && !rsp_dec) ? out_q + OutWidth'(1) :
                  (!load && rsp_dec) ? out_q - OutWidth'(1) : out_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            cfg_q   <= '0;
            id_q    <= '0;
            strb_q  <= '0;
            term_q  <= '0;
            out_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cfg_q   <= cfg_d;
            id_q    <= id_d;
            strb_q  <= strb_d;
            term_q  <= term_d;
            out_q   <= out_d;
        end
    end

    a_no_rsp_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rsp_hs && out_q == '0));
endmodule

// File: tb/tb_idma_init_write_pipe.sv
// tb_idma_init_write_pipe: randomized self-checking bench with a byte-level reference model
module tb_idma_init_write_pipe;
    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [3:0]   w_dp_offset_i = '0, w_dp_tailer_i = '0;
    logic         w_dp_valid_i = 1'b0, w_dp_ready_o, dp_poison_i = 1'b0;
    logic         w_dp_err_o, w_dp_valid_o, w_dp_ready_i = 1'b1;
    logic [31:0]  meta_cfg_i = '0;
    logic [3:0]   meta_id_i = '0;
    logic         meta_valid_i = 1'b0, meta_ready_o;
    logic         init_req_valid_o, init_req_ready_i = 1'b1;
    logic [31:0]  init_cfg_o;
    logic [3:0]   init_id_o;
    logic [127:0] init_term_o;
    logic [15:0]  init_strb_o;
    logic         init_rsp_valid_i = 1'b0, init_rsp_ready_o, init_rsp_err_i = 1'b0;
    logic [127:0] buffer_out_i = '0;
    logic [15:0]  buffer_out_valid_i = 16'hFFFF, buffer_out_ready_o;
    logic [2:0]   outstanding_o;
    logic         idle_o;

    int           n_cmp = 0, n_bad = 0, exp_out = 0;
    logic [15:0]  exp_mask, exp_strb;
    logic [127:0] exp_term;
    logic [31:0]  exp_cfg;
    logic [3:0]   exp_id;

    always #5 clk = ~clk;

    idma_init_write_pipe dut (
        .clk_i(clk), .rst_i(rst_i),
        .w_dp_offset_i(w_dp_offset_i), .w_dp_tailer_i(w_dp_tailer_i),
        .w_dp_valid_i(w_dp_valid_i), .w_dp_ready_o(w_dp_ready_o), .dp_poison_i(dp_poison_i),
        .w_dp_err_o(w_dp_err_o), .w_dp_valid_o(w_dp_valid_o), .w_dp_ready_i(w_dp_ready_i),
        .meta_cfg_i(meta_cfg_i), .meta_id_i(meta_id_i),
        .meta_valid_i(meta_valid_i), .meta_ready_o(meta_ready_o),
        .init_req_valid_o(init_req_valid_o), .init_req_ready_i(init_req_ready_i),
        .init_cfg_o(init_cfg_o), .init_id_o(init_id_o),
        .init_term_o(init_term_o), .init_strb_o(init_strb_o),
        .init_rsp_valid_i(init_rsp_valid_i), .init_rsp_ready_o(init_rsp_ready_o),
        .init_rsp_err_i(init_rsp_err_i),
        .buffer_out_i(buffer_out_i), .buffer_out_valid_i(buffer_out_valid_i),
        .buffer_out_ready_o(buffer_out_ready_o),
        .outstanding_o(outstanding_o), .idle_o(idle_o)
    );

    function automatic logic [15:0] ref_mask(input int off, input int tail);
        logic [15:0] m;
        for (int b = 0; b < 16; b++) m[b] = (b >= off) && (tail == 0 || b < tail);
        return m;
    endfunction

    function automatic logic [127:0] ref_term(input logic [127:0] d, input logic [15:0] m);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = m[b] ? d[8*b +: 8] : 8'h00;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic drive_beat(input int off, input int tail, input logic poison);
        w_dp_offset_i = 4'(off);
        w_dp_tailer_i = 4'(tail);
        dp_poison_i   = poison;
        buffer_out_i  = {$urandom, $urandom, $urandom, $urandom};
        meta_cfg_i    = $urandom;
        meta_id_i     = 4'($urandom);
        exp_mask      = ref_mask(off, tail);
        exp_term      = ref_term(buffer_out_i, exp_mask);
        exp_strb      = poison ? 16'h0 : exp_mask;
        exp_cfg       = meta_cfg_i;
        exp_id        = meta_id_i;
        w_dp_valid_i  = 1'b1;
        meta_valid_i  = 1'b1;
    endtask

    task automatic drain;
        w_dp_valid_i = 1'b0;
        meta_valid_i = 1'b0;
        init_req_ready_i = 1'b1;
        w_dp_ready_i = 1'b1;
        init_rsp_err_i = 1'b0;
        while (exp_out > 0) begin
            init_rsp_valid_i = 1'b1;
            tick;
            exp_out--;
        end
        init_rsp_valid_i = 1'b0;
        tick;
        n_cmp++;
        if (idle_o !== 1'b1 || outstanding_o !== 3'd0) begin
            n_bad++;
            $display("FAIL drain_idle: idle=%b outstanding=%0d, want idle=1 outstanding=0", idle_o, outstanding_o);
        end
    endtask

    task automatic test_reset;
        drive_beat(0, 0, 1'b0);
        settle;
        n_cmp++;
        if (buffer_out_ready_o !== 16'h0 || w_dp_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_pop: pop=%h wready=%b, want 0000/0", buffer_out_ready_o, w_dp_ready_o);
        end
        tick;
        tick;
        n_cmp++;
        if (init_req_valid_o !== 1'b0 || outstanding_o !== 3'd0 || idle_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b out=%0d idle=%b, want 0/0/1", init_req_valid_o, outstanding_o, idle_o);
        end
        n_cmp++;
        if (init_strb_o !== 16'h0 || init_term_o !== 128'h0 || init_cfg_o !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_payload: strb=%h cfg=%h, want zeros", init_strb_o, init_cfg_o);
        end
        w_dp_valid_i = 1'b0;
        meta_valid_i = 1'b0;
        rst_i = 1'b0;
        tick;
    endtask

    task automatic test_mask;
        buffer_out_valid_i = 16'hFFFF;
        drive_beat(4, 12, 1'b0);
        settle;
        n_cmp++;
        if (buffer_out_ready_o !== 16'h0FF0 || w_dp_ready_o !== 1'b1 || meta_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL mask_pop: pop=%h wready=%b mready=%b, want 0ff0/1/1", buffer_out_ready_o, w_dp_ready_o, meta_ready_o);
        end
        tick;
        exp_out++;
        w_dp_valid_i = 1'b0;
        meta_valid_i = 1'b0;
        n_cmp++;
        if (init_req_valid_o !== 1'b1 || init_strb_o !== 16'h0FF0) begin
            n_bad++;
            $display("FAIL mask_beat: valid=%b strb=%h, want 1/0ff0", init_req_valid_o, init_strb_o);
        end
        n_cmp++;
        if (init_term_o !== exp_term || init_cfg_o !== exp_cfg || init_id_o !== exp_id) begin
            n_bad++;
            $display("FAIL mask_term: term=%h want %h cfg=%h want %h", init_term_o, exp_term, init_cfg_o, exp_cfg);
        end
        drain;
    endtask

    task automatic test_partial_valid;
        buffer_out_valid_i = 16'h00FF;
        drive_beat(4, 12, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle;
            n_cmp++;
            if (buffer_out_ready_o !== 16'h0 || w_dp_ready_o !== 1'b0) begin
                n_bad++;
                $display("FAIL partial_wait: pop=%h wready=%b, want 0000/0", buffer_out_ready_o, w_dp_ready_o);
            end
            tick;
        end
        n_cmp++;
        if (init_req_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL partial_noload: valid=%b want 0", init_req_valid_o);
        end
        buffer_out_valid_i = 16'h0FF0;
        settle;
        n_cmp++;
        if (buffer_out_ready_o !== 16'h0FF0 || w_dp_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL partial_load: pop=%h wready=%b, want 0ff0/1", buffer_out_ready_o, w_dp_ready_o);
        end
        tick;
        exp_out++;
        n_cmp++;
        if (init_req_valid_o !== 1'b1 || init_term_o !== exp_term) begin
            n_bad++;
            $display("FAIL partial_beat: valid=%b term=%h want %h", init_req_valid_o, init_term_o, exp_term);
        end
        buffer_out_valid_i = 16'hFFFF;
        drain;
    endtask

    task automatic test_backpressure;
        logic [127:0] a_term;
        logic [15:0]  a_strb;
        logic [31:0]  a_cfg;
        init_req_ready_i = 1'b0;
        drive_beat(int'($urandom_range(0, 15)), 0, 1'b0);
        settle;
        n_cmp++;
        if (w_dp_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_first: wready=%b want 1", w_dp_ready_o);
        end
        tick;
        exp_out++;
        a_term = exp_term;
        a_strb = exp_strb;
        a_cfg  = exp_cfg;
        drive_beat(0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            settle;
            n_cmp++;
            if (w_dp_ready_o !== 1'b0 || init_req_valid_o !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_hold: wready=%b valid=%b, want 0/1", w_dp_ready_o, init_req_valid_o);
            end
            n_cmp++;
            if (init_term_o !== a_term || init_strb_o !== a_strb || init_cfg_o !== a_cfg) begin
                n_bad++;
                $display("FAIL bp_stable: term=%h want %h strb=%h want %h", init_term_o, a_term, init_strb_o, a_strb);
            end
            tick;
        end
        init_req_ready_i = 1'b1;
        settle;
        n_cmp++;
        if (w_dp_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_reload: wready=%b want 1", w_dp_ready_o);
        end
        tick;
        exp_out++;
        w_dp_valid_i = 1'b0;
        meta_valid_i = 1'b0;
        n_cmp++;
        if (init_req_valid_o !== 1'b1 || init_term_o !== exp_term || outstanding_o !== 3'(exp_out)) begin
            n_bad++;
            $display("FAIL bp_second: valid=%b term=%h want %h out=%0d want %0d", init_req_valid_o, init_term_o, exp_term, outstanding_o, exp_out);
        end
        drain;
    endtask

    task automatic test_outstanding;
        int loads;
        logic exp_ld;
        loads = 0;
        init_req_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_beat(int'($urandom_range(0, 15)), 0, 1'b0);
            settle;
            exp_ld = exp_out < 4;
            n_cmp++;
            if (w_dp_ready_o !== exp_ld) begin
                n_bad++;
                $display("FAIL credit_load%0d: wready=%b want %b", i, w_dp_ready_o, exp_ld);
            end
            if (w_dp_ready_o === 1'b1) loads++;
            tick;
            if (exp_ld) exp_out++;
        end
        n_cmp++;
        if (loads != 4 || outstanding_o !== 3'(exp_out)) begin
            n_bad++;
            $display("FAIL credit_count: loads=%0d out=%0d, want 4/%0d", loads, outstanding_o, exp_out);
        end
        init_rsp_valid_i = 1'b1;
        w_dp_ready_i = 1'b1;
        settle;
        n_cmp++;
        if (w_dp_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL credit_registered: wready=%b want 0", w_dp_ready_o);
        end
        tick;
        exp_out--;
        init_rsp_valid_i = 1'b0;
        n_cmp++;
        if (outstanding_o !== 3'(exp_out)) begin
            n_bad++;
            $display("FAIL credit_release: out=%0d want %0d", outstanding_o, exp_out);
        end
        settle;
        n_cmp++;
        if (w_dp_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL credit_fifth: wready=%b want 1", w_dp_ready_o);
        end
        tick;
        exp_out++;
        n_cmp++;
        if (outstanding_o !== 3'(exp_out)) begin
            n_bad++;
            $display("FAIL credit_full: out=%0d want %0d", outstanding_o, exp_out);
        end
        drain;
    endtask

    task automatic test_poison;
        drive_beat(int'($urandom_range(0, 7)), int'($urandom_range(8, 15)), 1'b1);
        settle;
        n_cmp++;
        if (buffer_out_ready_o !== exp_mask) begin
            n_bad++;
            $display("FAIL poison_pop: pop=%h want %h", buffer_out_ready_o, exp_mask);
        end
        tick;
        exp_out++;
        w_dp_valid_i = 1'b0;
        meta_valid_i = 1'b0;
        n_cmp++;
        if (init_strb_o !== 16'h0 || init_term_o !== exp_term) begin
            n_bad++;
            $display("FAIL poison_strb: strb=%h want 0000 term=%h want %h", init_strb_o, init_term_o, exp_term);
        end
        init_rsp_valid_i = 1'b1;
        init_rsp_err_i = 1'b1;
        settle;
        n_cmp++;
        if (w_dp_valid_o !== 1'b1 || w_dp_err_o !== 1'b1 || init_rsp_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL poison_err: rvalid=%b err=%b rready=%b, want 1/1/1", w_dp_valid_o, w_dp_err_o, init_rsp_ready_o);
        end
        tick;
        exp_out--;
        init_rsp_valid_i = 1'b0;
        init_rsp_err_i = 1'b0;
        drain;
    endtask

    task automatic test_random;
        logic exp_ld, err;
        init_req_ready_i = 1'b1;
        for (int i = 0; i < 25; i++) begin
            buffer_out_valid_i = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
            drive_beat(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            exp_ld = ((buffer_out_valid_i & exp_mask) == exp_mask) && (buffer_out_valid_i != 16'h0);
            settle;
            n_cmp++;
            if (buffer_out_ready_o !== (exp_ld ? exp_mask : 16'h0) || w_dp_ready_o !== exp_ld) begin
                n_bad++;
                $display("FAIL rand_pop%0d: pop=%h wready=%b, model mask=%h load=%b", i, buffer_out_ready_o, w_dp_ready_o, exp_mask, exp_ld);
            end
            tick;
            w_dp_valid_i = 1'b0;
            meta_valid_i = 1'b0;
            if (exp_ld) begin
                exp_out++;
                n_cmp++;
                if (init_req_valid_o !== 1'b1 || init_strb_o !== exp_strb || init_term_o !== exp_term
                    || init_cfg_o !== exp_cfg || init_id_o !== exp_id) begin
                    n_bad++;
                    $display("FAIL rand_beat%0d: strb=%h want %h term=%h want %h id=%h want %h", i, init_strb_o, exp_strb, init_term_o, exp_term, init_id_o, exp_id);
                end
                err = 1'($urandom_range(0, 1));
                init_rsp_valid_i = 1'b1;
                init_rsp_err_i = err;
                settle;
                n_cmp++;
                if (w_dp_valid_o !== 1'b1 || w_dp_err_o !== err) begin
                    n_bad++;
                    $display("FAIL rand_rsp%0d: rvalid=%b err=%b want 1/%b", i, w_dp_valid_o, w_dp_err_o, err);
                end
                tick;
                exp_out--;
                init_rsp_valid_i = 1'b0;
            end else begin
                n_cmp++;
                if (init_req_valid_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rand_noload%0d: valid=%b want 0", i, init_req_valid_o);
                end
            end
            n_cmp++;
            if (outstanding_o !== 3'(exp_out)) begin
                n_bad++;
                $display("FAIL rand_out%0d: out=%0d want %0d", i, outstanding_o, exp_out);
            end
        end
        buffer_out_valid_i = 16'hFFFF;
        drain;
    endtask

    task automatic test_reset_midbeat;
        init_req_ready_i = 1'b1;
        buffer_out_valid_i = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            drive_beat(int'($urandom_range(0, 15)), 0, 1'b0);
            tick;
            exp_out++;
        end
        n_cmp++;
        if (outstanding_o !== 3'(exp_out) || init_req_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_pre: out=%0d valid=%b, want %0d/1", outstanding_o, init_req_valid_o, exp_out);
        end
        rst_i = 1'b1;
        settle;
        n_cmp++;
        if (buffer_out_ready_o !== 16'h0 || w_dp_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_pop: pop=%h wready=%b, want 0000/0", buffer_out_ready_o, w_dp_ready_o);
        end
        tick;
        exp_out = 0;
        n_cmp++;
        if (init_req_valid_o !== 1'b0 || outstanding_o !== 3'd0 || idle_o !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_state: valid=%b out=%0d idle=%b, want 0/0/1", init_req_valid_o, outstanding_o, idle_o);
        end
        w_dp_valid_i = 1'b0;
        meta_valid_i = 1'b0;
        rst_i = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_mask;
        test_partial_valid;
        test_backpressure;
        test_outstanding;
        test_poison;
        test_random;
        test_reset_midbeat;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end
endmodule
